// File: rtl/wb_initiator.sv
// wb_initiator: single-transfer Wishbone pipelined master with retry and timeout handling
module wb_initiator #(
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        rsp_tmo_o,
    output logic        busy_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    input  logic        wb_stall_i,
    input  logic [31:0] wb_dat_i
);
    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT} state_t;

    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  retry_q, retry_d;
    logic [15:0] tmo_q, tmo_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_tmo_q, rsp_tmo_d;
    logic        accept, in_wait, term, fin_ack, fin_err, fin_tmo, do_retry;

    // Classify this cycle's outcome; slave replies only count in WAIT, err beats ack beats rty
    always_comb begin
        accept   = cmd_valid_i & cmd_ready_o;
        in_wait  = state_q == S_WAIT;
        term     = in_wait & (wb_ack_i | wb_err_i | wb_rty_i);
        fin_ack  = in_wait & wb_ack_i & ~wb_err_i;
        do_retry = in_wait & wb_rty_i & ~wb_ack_i & ~wb_err_i & (retry_q < RETRY_LIM);
        fin_err  = in_wait & (wb_err_i | (wb_rty_i & ~wb_ack_i & ~(retry_q < RETRY_LIM)));
        fin_tmo  = (state_q != S_IDLE) & ~term & (tmo_q == TMO_LAST);
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = accept ? S_STROBE : S_IDLE;
            S_STROBE: state_d = fin_tmo ? S_IDLE : (wb_stall_i ? S_STROBE : S_WAIT);
            S_WAIT:   state_d = do_retry ? S_STROBE : ((fin_ack | fin_err | fin_tmo) ? S_IDLE : S_WAIT);
            default:  state_d = S_IDLE;
        endcase
    end

    // Bus control and handshake outputs decoded from state
    always_comb begin
        cmd_ready_o = (state_q == S_IDLE) & ~rst_i;
        busy_o      = state_q != S_IDLE;
        wb_cyc_o    = state_q != S_IDLE;
        wb_stb_o    = state_q == S_STROBE;
    end

    // Command capture, retry/timeout counters and response formation
    always_comb begin
        we_d        = accept ? cmd_we_i  : we_q;
        adr_d       = accept ? cmd_adr_i : adr_q;
        dat_d       = accept ? cmd_dat_i : dat_q;
        sel_d       = accept ? cmd_sel_i : sel_q;
        retry_d     = accept ? 4'd0 : (do_retry ? retry_q + 4'd1 : retry_q);
        tmo_d       = (accept | do_retry) ? 16'd0 : ((state_q != S_IDLE) ? tmo_q + 16'd1 : tmo_q);
        rsp_valid_d = fin_ack | fin_err | fin_tmo;
        rsp_err_d   = rsp_valid_d ? (fin_err | fin_tmo) : rsp_err_q;
        rsp_tmo_d   = rsp_valid_d ? (fin_tmo & ~fin_err) : rsp_tmo_q;
        rsp_dat_d   = rsp_valid_d ? ((fin_ack & ~we_q) ? wb_dat_i : 32'd0) : rsp_dat_q;
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q        <= 1'b0;
            adr_q       <= 32'd0;
            dat_q       <= 32'd0;
            sel_q       <= 4'd0;
            retry_q     <= 4'd0;
            tmo_q       <= 16'd0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'd0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            retry_q     <= retry_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_tmo_o   = rsp_tmo_q;
endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: scripted slave with a transaction-level expectation model for wb_initiator
module tb_wb_initiator;
    localparam int TMO = 8;
    localparam int MR  = 3;
    localparam int R_ACK = 0, R_ERR = 1, R_RTY = 2, R_BOTH = 3, R_NONE = 4;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0] cmd_adr_i, cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o, rsp_err_o, rsp_tmo_o, busy_o;
    logic [31:0] rsp_dat_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;

    int checks = 0, errors = 0, cyc_no = 0;
    int stb_seen = 0, cyc_seen = 0, rv_seen = 0, rv_cycle = 0, acc = 0;
    logic        chk_en = 1'b0;
    logic        exp_cyc, exp_stb, exp_rdy, exp_rv, exp_rerr, exp_rtmo;
    logic [31:0] exp_rdat;
    logic        m_we;
    logic [31:0] m_adr, m_dat, rd_val;
    logic [3:0]  m_sel;
    int att_stall[8], att_wt[8], att_rep[8];

    wb_initiator #(.TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .rsp_tmo_o(rsp_tmo_o), .busy_o(busy_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .wb_stall_i(wb_stall_i), .wb_dat_i(wb_dat_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc_no <= cyc_no + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc_no);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_att(input int i, input int s, input int w, input int r);
        att_stall[i] = s;
        att_wt[i]    = w;
        att_rep[i]   = r;
    endtask

    // Every-cycle comparison of DUT outputs against the model's expectations
    always @(negedge clk_i) begin
        if (wb_stb_o) stb_seen++;
        if (wb_cyc_o) cyc_seen++;
        if (rsp_valid_o) begin
            rv_seen++;
            rv_cycle = cyc_no;
        end
        if (chk_en) begin
            chk("cyc", wb_cyc_o, exp_cyc);
            chk("stb", wb_stb_o, exp_stb);
            chk("busy", busy_o, exp_cyc);
            chk("ready", cmd_ready_o, exp_rdy);
            chk("rsp_valid", rsp_valid_o, exp_rv);
            chk("rsp_dat", rsp_dat_o, exp_rdat);
            chk("rsp_err", rsp_err_o, exp_rerr);
            chk("rsp_tmo", rsp_tmo_o, exp_rtmo);
            if (exp_cyc) begin
                chk("adr", wb_adr_o, m_adr);
                chk("wdat", wb_dat_o, m_dat);
                chk("we", wb_we_o, m_we);
                chk("sel", wb_sel_o, m_sel);
            end
        end
    end

    // One command; attempts come from att_* (stall cycles, idle wait cycles, reply kind)
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic noise);
        int a, c, r, retries;
        logic done, nxt, strobe, p_err, p_tmo;
        logic [31:0] p_dat;
        stb_seen = 0; cyc_seen = 0; rv_seen = 0;
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
        wb_stall_i = 1'b0; wb_ack_i = noise; wb_err_i = noise; wb_rty_i = noise; wb_dat_i = $urandom;
        exp_cyc = 1'b0; exp_stb = 1'b0; exp_rdy = 1'b1; exp_rv = 1'b0;
        m_we = we; m_adr = adr; m_dat = dat; m_sel = sel;
        acc = cyc_no;
        step();
        cmd_valid_i = 1'b0; cmd_we_i = ~we; cmd_adr_i = ~adr; cmd_dat_i = ~dat; cmd_sel_i = ~sel;
        a = 0; retries = 0; done = 1'b0; p_err = 1'b0; p_tmo = 1'b0; p_dat = 32'd0;
        while (!done) begin
            r = (att_rep[a] == R_NONE) ? (1 << 20) : att_stall[a] + 1 + att_wt[a];
            c = 0; nxt = 1'b0;
            while (!done && !nxt) begin
                strobe     = c <= att_stall[a];
                wb_stall_i = c < att_stall[a];
                wb_ack_i   = strobe ? noise : (c == r && (att_rep[a] == R_ACK || att_rep[a] == R_BOTH));
                wb_err_i   = strobe ? noise : (c == r && (att_rep[a] == R_ERR || att_rep[a] == R_BOTH));
                wb_rty_i   = strobe ? noise : (c == r && att_rep[a] == R_RTY);
                wb_dat_i   = (c == r) ? rd_val : $urandom;
                exp_cyc = 1'b1; exp_stb = strobe; exp_rdy = 1'b0; exp_rv = 1'b0;
                if (c == r) begin
                    if (att_rep[a] == R_ACK) begin
                        done = 1'b1;
                        p_dat = we ? 32'd0 : rd_val;
                    end else if (att_rep[a] == R_RTY && retries < MR) begin
                        retries++;
                        nxt = 1'b1;
                    end else begin
                        done = 1'b1;
                        p_err = 1'b1;
                    end
                end else if (c == TMO - 1) begin
                    done = 1'b1; p_err = 1'b1; p_tmo = 1'b1;
                end
                step();
                c++;
            end
            if (nxt) a++;
        end
        wb_stall_i = 1'b0; wb_ack_i = noise; wb_err_i = noise; wb_rty_i = noise;
        exp_cyc = 1'b0; exp_stb = 1'b0; exp_rdy = 1'b1; exp_rv = 1'b1;
        exp_rdat = p_dat; exp_rerr = p_err; exp_rtmo = p_tmo;
        step();
        exp_rv = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_dat_i = '0; cmd_sel_i = '0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_stall_i = 1'b0; wb_dat_i = '0;
        rd_val = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_wdat", wb_dat_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_rv", rsp_valid_o, 0);
        chk("rst_rdat", rsp_dat_o, 0);
        chk("rst_rerr", rsp_err_o, 0);
        chk("rst_rtmo", rsp_tmo_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", cmd_ready_o, 0);
        step();
        rst_i = 1'b0;
        exp_cyc = 1'b0; exp_stb = 1'b0; exp_rdy = 1'b1; exp_rv = 1'b0;
        exp_rdat = '0; exp_rerr = 1'b0; exp_rtmo = 1'b0;
        m_we = 1'b0; m_adr = '0; m_dat = '0; m_sel = '0;
        chk_en = 1'b1;
        step();

        set_att(0, 0, 0, R_ACK); rd_val = 32'hDEADBEEF;
        run_txn(1'b0, 32'h4, 32'h0, 4'hF, 1'b0);
        chk("t1_latency", rv_cycle - acc, 3);
        chk("t1_stb_cycles", stb_seen, 1);
        chk("t1_rdat", rsp_dat_o, 32'hDEADBEEF);
        chk("t1_err", rsp_err_o, 0);

        set_att(0, 3, 0, R_ACK); rd_val = 32'hCAFEF00D;
        run_txn(1'b1, 32'h0, 32'h12345678, 4'hF, 1'b0);
        chk("t2_stb_cycles", stb_seen, 4);
        chk("t2_latency", rv_cycle - acc, 6);
        chk("t2_rdat", rsp_dat_o, 0);
        chk("t2_err", rsp_err_o, 0);

        for (int i = 0; i < 3; i++) set_att(i, 0, 0, R_RTY);
        set_att(3, 0, 0, R_ACK); rd_val = 32'h00C0FFEE;
        run_txn(1'b0, 32'h100, 32'h0, 4'h3, 1'b0);
        chk("t3_stb_cycles", stb_seen, 4);
        chk("t3_rsp_count", rv_seen, 1);
        chk("t3_err", rsp_err_o, 0);

        for (int i = 0; i < 4; i++) set_att(i, 0, 0, R_RTY);
        run_txn(1'b0, 32'h104, 32'h0, 4'h1, 1'b0);
        chk("t4_stb_cycles", stb_seen, 4);
        chk("t4_err", rsp_err_o, 1);
        chk("t4_tmo", rsp_tmo_o, 0);

        set_att(0, 0, 0, R_NONE);
        run_txn(1'b0, 32'h200, 32'h0, 4'hF, 1'b0);
        chk("t5_cyc_cycles", cyc_seen, 8);
        chk("t5_err", rsp_err_o, 1);
        chk("t5_tmo", rsp_tmo_o, 1);

        set_att(0, 2, 2, R_ACK); rd_val = 32'hA5A55A5A;
        run_txn(1'b0, 32'h300, 32'h0, 4'hC, 1'b1);
        chk("t9_rdat", rsp_dat_o, 32'hA5A55A5A);
        chk("t9_tmo", rsp_tmo_o, 0);

        set_att(0, 0, 1, R_BOTH); rd_val = 32'h11112222;
        run_txn(1'b0, 32'h400, 32'h0, 4'hF, 1'b0);
        chk("t6_err", rsp_err_o, 1);
        chk("t6_rdat", rsp_dat_o, 0);

        chk_en = 1'b0; rv_seen = 0;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'h40; cmd_sel_i = 4'h3;
        step();
        cmd_valid_i = 1'b0;
        step();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rw_cyc_before", wb_cyc_o, 1);
        chk("rw_stb_before", wb_stb_o, 0);
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rw_cyc_after", wb_cyc_o, 0);
        chk("rw_ready_after", cmd_ready_o, 1);
        chk("rw_rsp_err", rsp_err_o, 0);
        chk("rw_adr", wb_adr_o, 0);
        chk("rw_no_rsp", rv_seen, 0);
        step();
        exp_cyc = 1'b0; exp_stb = 1'b0; exp_rdy = 1'b1; exp_rv = 1'b0;
        exp_rdat = '0; exp_rerr = 1'b0; exp_rtmo = 1'b0;
        chk_en = 1'b1;
        set_att(0, 1, 0, R_ACK); rd_val = 32'h5EED5EED;
        run_txn(1'b0, 32'h44, 32'h0, 4'hF, 1'b0);
        chk("rw_next_rdat", rsp_dat_o, 32'h5EED5EED);

        set_att(0, 0, 6, R_ACK); rd_val = 32'h77778888;
        run_txn(1'b0, 32'h500, 32'h0, 4'hF, 1'b0);
        chk("t7_tmo", rsp_tmo_o, 0);
        chk("t7_err", rsp_err_o, 0);
        chk("t7_cyc_cycles", cyc_seen, 8);

        set_att(0, 20, 0, R_NONE);
        run_txn(1'b1, 32'h600, 32'hFFFF0000, 4'h8, 1'b0);
        chk("t8_cyc_cycles", cyc_seen, 8);
        chk("t8_tmo", rsp_tmo_o, 1);

        set_att(0, 1, 2, R_RTY);
        set_att(1, 1, 2, R_ACK); rd_val = 32'h0BADF00D;
        run_txn(1'b0, 32'h700, 32'h0, 4'hF, 1'b0);
        chk("t10_cyc_cycles", cyc_seen, 10);
        chk("t10_err", rsp_err_o, 0);
        chk("t10_rdat", rsp_dat_o, 32'h0BADF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles from strobe issue to termination (range 1..65535).
REQ-002 SHALL have parameter MAX_RETRY, default 3, retries allowed on wb_rty_i (range 0..15).
REQ-003 SHALL have port clk_i  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid_i  in  1  command present.
REQ-006 SHALL have port cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
REQ-007 SHALL have ports cmd_we_i in 1, cmd_adr_i in 32, cmd_dat_i in 32, cmd_sel_i in 4: write flag, byte address, write data, byte lanes.
REQ-008 SHALL have ports rsp_valid_o out 1, rsp_dat_o out 32, rsp_err_o out 1, rsp_tmo_o out 1: one-cycle response pulse, read data, error flag, timeout flag.
REQ-009 SHALL have port busy_o  out  1  high when not IDLE.
REQ-010 SHALL have Wishbone pipelined master ports wb_cyc_o, wb_stb_o, wb_we_o (out 1), wb_adr_o (out 32), wb_sel_o (out 4), wb_dat_o (out 32), wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i (in 1), wb_dat_i (in 32).

Function
REQ-011 SHALL implement FSM states IDLE, STROBE, WAIT.
REQ-012 cmd_ready_o SHALL be high only in IDLE; on cmd_valid_i & cmd_ready_o, command fields SHALL be registered and state SHALL be STROBE next cycle.
REQ-013 In STROBE: wb_cyc_o=1, wb_stb_o=1; stays while wb_stall_i=1; on wb_stall_i=0 goes to WAIT next cycle.
REQ-014 In WAIT: wb_cyc_o=1, wb_stb_o=0; wb_ack_i/err_i/rty_i SHALL be sampled only in WAIT, ignored in IDLE and STROBE.
REQ-015 wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o SHALL hold the registered command, unchanged from STROBE entry until return to IDLE.
REQ-016 Termination priority in WAIT: err > ack > rty.
REQ-017 On ack: next cycle IDLE, cyc low, rsp_valid_o=1, rsp_err_o=0, rsp_dat_o=wb_dat_i sampled with ack for reads, 0 for writes.
REQ-018 On err: next cycle IDLE, rsp_valid_o=1, rsp_err_o=1, rsp_dat_o=0.
REQ-019 On rty with retry count < MAX_RETRY: increment retry count, return to STROBE next cycle, no response; otherwise behave as err.
REQ-020 Retry count (4 bits) SHALL clear on command acceptance.
REQ-021 Timeout counter (16 bits) SHALL clear on every STROBE entry, increment each cycle in STROBE or WAIT; when it equals TIMEOUT-1 with no termination that cycle: next cycle IDLE, cyc low, rsp_valid_o=1, rsp_err_o=1, rsp_tmo_o=1, rsp_dat_o=0.
REQ-022 Termination and timeout in the same cycle: termination wins.
REQ-023 rsp_valid_o SHALL be exactly one cycle wide, coincident with the first IDLE cycle; no backpressure; rsp_dat_o/err/tmo SHALL hold until next response.
REQ-024 Minimum latency: command accept at cycle 0, stb cycle 1 (no stall), ack cycle 2, rsp_valid_o and cmd_ready_o cycle 3.
REQ-025 busy_o SHALL equal (state != IDLE).

Reset
REQ-026 While rst_i=1: state IDLE, counters 0, wb_cyc_o/wb_stb_o/wb_we_o=0, wb_adr_o/wb_dat_o=0, wb_sel_o=0, rsp_*=0, busy_o=0, cmd_ready_o=0.
REQ-027 Reset asserted mid-transaction SHALL drop cyc/stb the cycle after rst_i is sampled, with no response pulse; cmd_ready_o=1 the first cycle after rst_i deasserts.

Verification
REQ-028 Read adr 0x04, slave no stall, ack next cycle with 0xDEADBEEF -> stb one cycle, rsp_valid_o at accept+3, rsp_dat_o=0xDEADBEEF, err=0.
REQ-029 Write adr 0x00 dat 0x12345678 sel 0xF, stall 3 cycles -> stb 4 cycles, adr/dat stable, rsp_valid_o with rsp_dat_o=0, err=0.
REQ-030 MAX_RETRY=3, slave rty 3 times then ack -> 4 strobes, one rsp_valid_o, err=0; rty 4 times -> 4 strobes, rsp_err_o=1, rsp_tmo_o=0.
REQ-031 TIMEOUT=8, slave never acks -> cyc high exactly 8 cycles, rsp_valid_o with err=1, tmo=1.
REQ-032 ack and err same cycle -> rsp_err_o=1, rsp_dat_o=0; ack on TIMEOUT-1 cycle -> rsp_tmo_o=0.
REQ-033 rst_i pulsed during WAIT -> cyc low next cycle, no rsp_valid_o, next command completes normally.
